// File: rtl/video_pkg.sv
// Shared video timing constants and helpers for the pony video pipeline.
//   - VGA_640x480_* / SVGA_800x600_*: active, front porch, sync, back porch, sync polarity.
//   - total(): full period of one axis from its four region lengths.
package video_pkg;

    localparam int unsigned VGA_640x480_H_ACTIVE = 640;
    localparam int unsigned VGA_640x480_H_FRONT  = 16;
    localparam int unsigned VGA_640x480_H_SYNC   = 96;
    localparam int unsigned VGA_640x480_H_BACK   = 48;
    localparam int unsigned VGA_640x480_V_ACTIVE = 480;
    localparam int unsigned VGA_640x480_V_FRONT  = 10;
    localparam int unsigned VGA_640x480_V_SYNC   = 2;
    localparam int unsigned VGA_640x480_V_BACK   = 33;
    localparam bit          VGA_640x480_H_POL    = 1'b0;
    localparam bit          VGA_640x480_V_POL    = 1'b0;

    localparam int unsigned SVGA_800x600_H_ACTIVE = 800;
    localparam int unsigned SVGA_800x600_H_FRONT  = 40;
    localparam int unsigned SVGA_800x600_H_SYNC   = 128;
    localparam int unsigned SVGA_800x600_H_BACK   = 88;
    localparam int unsigned SVGA_800x600_V_ACTIVE = 600;
    localparam int unsigned SVGA_800x600_V_FRONT  = 1;
    localparam int unsigned SVGA_800x600_V_SYNC   = 4;
    localparam int unsigned SVGA_800x600_V_BACK   = 23;
    localparam bit          SVGA_800x600_H_POL    = 1'b1;
    localparam bit          SVGA_800x600_V_POL    = 1'b1;

    function automatic int unsigned total(input int unsigned active, input int unsigned front,
                                          input int unsigned sync, input int unsigned back);
        return active + front + sync + back;
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo counter 0..TERMINAL that advances when inc is high.
//   clk   : clock
//   reset : synchronous active-high reset, count returns to 0
//   inc   : advance enable
//   count : current value
//   last  : combinational, high while count == TERMINAL
module wrap_counter #(
    parameter int unsigned WIDTH    = 10,
    parameter int unsigned TERMINAL = 799
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             last
);

    localparam logic [WIDTH-1:0] TERM = WIDTH'(TERMINAL);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc) begin
            count_d = (count_q == TERM) ? '0 : count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign last  = (count_q == TERM);

endmodule

// File: rtl/svga_timing_gen.sv
// Parametrised raster timing generator.
//   clk           : pixel clock
//   reset         : synchronous active-high reset
//   hsync/vsync   : sync pulses, active level H_POL / V_POL
//   de            : display enable, high inside the active area
//   x/y           : active-area coordinates shifted right by SCALE_LOG2, 0 in blanking
//   next_vertical : one-clock strobe on the last clock of every line
//   next_frame    : one-clock strobe on the last clock of the frame
//   frame_cnt     : completed-frame count, wraps
// Every output is a registered decode of the counters, so outputs lag the counters by one clock.
module svga_timing_gen
    import video_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FRONT    = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BACK     = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FRONT    = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BACK     = 33,
    parameter bit          H_POL      = 1'b0,
    parameter bit          V_POL      = 1'b0,
    parameter int unsigned SCALE_LOG2 = 0,
    parameter int unsigned FRAME_W    = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    output logic                        hsync,
    output logic                        vsync,
    output logic                        de,
    output logic [$clog2(H_ACTIVE)-1:0] x,
    output logic [$clog2(V_ACTIVE)-1:0] y,
    output logic                        next_vertical,
    output logic                        next_frame,
    output logic [FRAME_W-1:0]          frame_cnt
);

    localparam int unsigned H_TOTAL = total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL = total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned XW      = $clog2(H_ACTIVE);
    localparam int unsigned YW      = $clog2(V_ACTIVE);

    localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FRONT);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FRONT);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FRONT + V_SYNC);

    // Parameter sanity checks at elaboration.
    if (H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
        V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_porch
        $error("svga_timing_gen: every porch and sync width must be at least 1");
    end
    if (SCALE_LOG2 > 3) begin : g_bad_scale
        $error("svga_timing_gen: SCALE_LOG2 must be 0..3");
    end
    if ((H_ACTIVE % (1 << SCALE_LOG2)) != 0 ||
        (V_ACTIVE % (1 << SCALE_LOG2)) != 0) begin : g_bad_active
        $error("svga_timing_gen: active size must be a multiple of 2**SCALE_LOG2");
    end

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_last;
    logic          v_last;

    wrap_counter #(
        .WIDTH    (HW),
        .TERMINAL (H_TOTAL - 1)
    ) u_h_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (1'b1),
        .count (h_cnt),
        .last  (h_last)
    );

    // Lines advance only on the final clock of each line.
    wrap_counter #(
        .WIDTH    (VW),
        .TERMINAL (V_TOTAL - 1)
    ) u_v_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (h_last),
        .count (v_cnt),
        .last  (v_last)
    );

    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               de_q, de_d;
    logic [XW-1:0]      x_q, x_d;
    logic [YW-1:0]      y_q, y_d;
    logic               nv_q, nv_d;
    logic               nf_q, nf_d;
    logic [FRAME_W-1:0] frame_q, frame_d;

    logic h_act, v_act, h_in_sync, v_in_sync;

    always_comb begin
        h_act     = (h_cnt < H_ACT_END);
        v_act     = (v_cnt < V_ACT_END);
        h_in_sync = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
        v_in_sync = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);

        hsync_d = h_in_sync ? H_POL : ~H_POL;
        vsync_d = v_in_sync ? V_POL : ~V_POL;
        de_d    = h_act && v_act;
        x_d     = h_act ? XW'(h_cnt >> SCALE_LOG2) : '0;
        y_d     = v_act ? YW'(v_cnt >> SCALE_LOG2) : '0;
        nv_d    = h_last;
        nf_d    = h_last && v_last;
        // The count shows the new value in the same cycle as the frame strobe.
        frame_d = nf_d ? frame_q + FRAME_W'(1) : frame_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_q <= ~H_POL;
            vsync_q <= ~V_POL;
            de_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            nv_q    <= 1'b0;
            nf_q    <= 1'b0;
            frame_q <= '0;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            x_q     <= x_d;
            y_q     <= y_d;
            nv_q    <= nv_d;
            nf_q    <= nf_d;
            frame_q <= frame_d;
        end
    end

    assign hsync         = hsync_q;
    assign vsync         = vsync_q;
    assign de            = de_q;
    assign x             = x_q;
    assign y             = y_q;
    assign next_vertical = nv_q;
    assign next_frame    = nf_q;
    assign frame_cnt     = frame_q;

endmodule
